branch_target_unit: RTL and testbench

- Parametrised successor to the Execute-stage PC-target adder.
- Computes the resolved branch/jump target in Execute (PC+imm, or JALR rs1+imm with LSB cleared).
- Keeps a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, which supplies a predicted next PC to Fetch.
- Flags mispredictions back to the hazard unit.

---
 rtl/branch_target_unit.sv | 130 +++++++++++++
 tb/tb_branch_target_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_unit.sv
// branch_target_unit: Execute-stage target adder plus direct-mapped BTB.
// Fetch looks up a prediction; Execute resolves, trains and flags mispredicts.
//
// Parameters:
//   XLEN    datapath/PC width
//   ENTRIES BTB entries (power of 2, >= 2)
// Ports:
//   clk, rst         clock, async active-high reset
//   flush_all        invalidate every BTB entry on the next edge
//   pc_f             Fetch PC for lookup
//   pred_taken_f     redirect Fetch
//   pred_target_f    predicted target (0 on miss)
//   update_e         resolved branch/JAL/JALR in Execute
//   pc_e, imm_ext_e  PC and sign-extended immediate
//   rs1_e, is_jalr_e JALR base and form select
//   taken_e          actual outcome
//   pred_taken_e     prediction carried from Fetch
//   pred_target_e    predicted target carried from Fetch
//   pc_target_e      resolved target
//   mispredict_e     Fetch must be redirected
// Option BTB_STATS_EN adds stat_updates/stat_mispredicts counters.
module branch_target_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_all,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            update_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] rs1_e,
  input  logic            is_jalr_e,
  input  logic            taken_e,
  input  logic            pred_taken_e,
  input  logic [XLEN-1:0] pred_target_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            mispredict_e
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  logic             valid [ENTRIES];
  logic [TAG_W-1:0] tags  [ENTRIES];
  logic [XLEN-1:0]  tgts  [ENTRIES];
  logic [1:0]       ctrs  [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic [XLEN-1:0]  sum_e;
  logic             unused_lsbs;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[XLEN-1:IDX_W+2];
  assign idx_e = pc_e[IDX_W+1:2];
  assign tag_e = pc_e[XLEN-1:IDX_W+2];
  assign unused_lsbs = ^{pc_f[1:0], pc_e[1:0]};

  assign hit_f = valid[idx_f] && (tags[idx_f] == tag_f);
  assign hit_e = valid[idx_e] && (tags[idx_e] == tag_e);

  assign pred_taken_f  = hit_f && ctrs[idx_f][1];
  assign pred_target_f = hit_f ? tgts[idx_f] : '0;

  // JALR clears bit 0 of the sum; other forms are PC-relative.
  assign sum_e = (is_jalr_e ? rs1_e : pc_e) + imm_ext_e;
  assign pc_target_e = is_jalr_e ? {sum_e[XLEN-1:1], 1'b0} : sum_e;

  always_comb begin
    mispredict_e = 1'b0;
    if (update_e) begin
      mispredict_e = (taken_e != pred_taken_e) ||
                     (taken_e && pred_taken_e &&
                      (pc_target_e != pred_target_e));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        tags[i]  <= '0;
        tgts[i]  <= '0;
        ctrs[i]  <= 2'b01;
      end
    end else begin
      if (update_e) begin
        if (hit_e) begin
          if (taken_e) begin
            if (ctrs[idx_e] != 2'b11) ctrs[idx_e] <= ctrs[idx_e] + 2'd1;
            tgts[idx_e] <= pc_target_e;
          end else if (ctrs[idx_e] != 2'b00) begin
            ctrs[idx_e] <= ctrs[idx_e] - 2'd1;
          end
        end else if (taken_e) begin
          valid[idx_e] <= 1'b1;
          tags[idx_e]  <= tag_e;
          tgts[idx_e]  <= pc_target_e;
          ctrs[idx_e]  <= 2'b10;
        end
      end
      // Later assignment: flush overrides a same-cycle allocate.
      if (flush_all) begin
        for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update_e)     stat_updates     <= stat_updates + 32'd1;
      if (mispredict_e) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// tb_branch_target_unit: directed plan steps plus random traffic
// checked against a table-based BTB reference model.
module tb_branch_target_unit;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush_all = 0;
  logic [31:0] pc_f = 0;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        update_e = 0;
  logic [31:0] pc_e = 0, imm_ext_e = 0, rs1_e = 0;
  logic        is_jalr_e = 0, taken_e = 0, pred_taken_e = 0;
  logic [31:0] pred_target_e = 0;
  logic [31:0] pc_target_e;
  logic        mispredict_e;
`ifdef BTB_STATS_EN
  logic [31:0] stat_updates, stat_mispredicts;
  int          m_upd, m_mis;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: one record per BTB slot.
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];

  always #5 clk = ~clk;

  branch_target_unit dut (
    .clk(clk), .rst(rst), .flush_all(flush_all),
    .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .pred_target_f(pred_target_f), .update_e(update_e),
    .pc_e(pc_e), .imm_ext_e(imm_ext_e), .rs1_e(rs1_e),
    .is_jalr_e(is_jalr_e), .taken_e(taken_e),
    .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
    .pc_target_e(pc_target_e), .mispredict_e(mispredict_e)
`ifdef BTB_STATS_EN
    , .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tagof(logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_v[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] t;
    if (is_jalr_e) begin
      t = rs1_e + imm_ext_e;
      t = t - (t % 2);
    end else begin
      t = pc_e + imm_ext_e;
    end
    return t;
  endfunction

  function automatic bit m_mispred();
    if (!update_e) return 0;
    if (taken_e != pred_taken_e) return 1;
    return taken_e && pred_taken_e && (m_target() != pred_target_e);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
`ifdef BTB_STATS_EN
    m_upd = 0; m_mis = 0;
`endif
  endtask

  // Compare every output with the model for the current inputs.
  task automatic check_all(string tag);
    bit h;
    h = m_hit(pc_f);
    chk({tag, ".pt"}, 32'(pred_taken_f), 32'(h && m_ctr[slot(pc_f)] >= 2));
    chk({tag, ".ptg"}, pred_target_f, h ? m_tgt[slot(pc_f)] : 32'h0);
    chk({tag, ".tgt"}, pc_target_e, m_target());
    chk({tag, ".mis"}, 32'(mispredict_e), 32'(m_mispred()));
`ifdef BTB_STATS_EN
    chk({tag, ".su"}, stat_updates, 32'(m_upd));
    chk({tag, ".sm"}, stat_mispredicts, 32'(m_mis));
`endif
  endtask

  task automatic tick();
    int s;
    bit mis;
    mis = m_mispred();
    @(posedge clk);
    if (update_e) begin
      s = slot(pc_e);
      if (m_hit(pc_e)) begin
        if (taken_e) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = m_target();
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (taken_e) begin
        m_v[s] = 1; m_tag[s] = tagof(pc_e);
        m_tgt[s] = m_target(); m_ctr[s] = 2;
      end
`ifdef BTB_STATS_EN
      m_upd++;
      if (mis) m_mis++;
`endif
    end
    if (flush_all) for (int i = 0; i < 16; i++) m_v[i] = 0;
    @(negedge clk);
  endtask

  task automatic drive(bit upd, logic [31:0] pe, logic [31:0] im,
                       logic [31:0] r1, bit jr, bit tk, bit pt,
                       logic [31:0] ptg, logic [31:0] pf, bit fl);
    update_e = upd; pc_e = pe; imm_ext_e = im; rs1_e = r1;
    is_jalr_e = jr; taken_e = tk; pred_taken_e = pt;
    pred_target_e = ptg; pc_f = pf; flush_all = fl;
    #1;
  endtask

  task automatic idle(logic [31:0] pf);
    drive(0, 0, 0, 0, 0, 0, 0, 0, pf, 0);
  endtask

  logic [31:0] pool [8];

  initial begin
    m_reset();
    pool = '{32'h100, 32'h140, 32'h104, 32'h2000,
             32'h3000, 32'h1100, 32'hFFFFFFF0, 32'h13C};
    repeat (2) @(negedge clk);
    rst = 0;

    // Learn a taken branch at 0x100.
    drive(1, 32'h100, 32'h20, 0, 0, 1, 0, 0, 32'h100, 0);
    chk("rst_pt", 32'(pred_taken_f), 32'h0);
    chk("rst_ptg", pred_target_f, 32'h0);
    chk("first_tgt", pc_target_e, 32'h120);
    chk("first_mis", 32'(mispredict_e), 32'h1);
    check_all("s1");
    tick();
    idle(32'h100);
    chk("learn_pt", 32'(pred_taken_f), 32'h1);
    chk("learn_ptg", pred_target_f, 32'h120);
    check_all("s2");

    // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100, 32'h20, 0, 0, 0, 0, 0, 32'h100, 0);
      check_all("walk_nt");
      tick();
    end
    idle(32'h100);
    chk("walk_low", 32'(pred_taken_f), 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h100, 32'h20, 0, 0, 1, 0, 0, 32'h100, 0);
      check_all("walk_t");
      tick();
    end
    idle(32'h100);
    chk("walk_high", 32'(pred_taken_f), 32'h1);

    // Aliasing: 0x140 shares the slot of 0x100.
    drive(1, 32'h140, 32'h8, 0, 0, 1, 0, 0, 32'h140, 0);
    check_all("alias");
    tick();
    idle(32'h100);
    chk("alias_old", 32'(pred_taken_f), 32'h0);
    idle(32'h140);
    chk("alias_new", 32'(pred_taken_f), 32'h1);
    chk("alias_tgt", pred_target_f, 32'h148);

    // JALR with wrong predicted target.
    drive(1, 32'h3000, 32'h4, 32'h2003, 1, 1, 1, 32'h2000, 0, 0);
    chk("jalr_tgt", pc_target_e, 32'h2006);
    chk("jalr_mis", 32'(mispredict_e), 32'h1);
    tick();
    idle(32'h3000);
    chk("jalr_btb", pred_target_f, 32'h2006);

    // Wrap-around target.
    drive(1, 32'hFFFFFFF0, 32'h20, 0, 0, 1, 0, 0, 0, 0);
    chk("wrap_tgt", pc_target_e, 32'h10);
    check_all("wrap");
    tick();

    // Flush and update together on trained slot.
    drive(1, 32'h140, 32'h8, 0, 0, 1, 1, 32'h148, 32'h140, 1);
    check_all("flush");
    chk("flush_nomis", 32'(mispredict_e), 32'h0);
    tick();
    idle(32'h140);
    chk("flush_pt", 32'(pred_taken_f), 32'h0);

    // Random traffic over a small aliasing PC pool.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pe, pf, ptg;
      bit pt;
      pe = pool[$urandom_range(7)];
      pf = pool[$urandom_range(7)];
      pt = m_hit(pe) && m_ctr[slot(pe)] >= 2;
      ptg = m_hit(pe) ? m_tgt[slot(pe)] : 32'h0;
      if ($urandom_range(3) == 0) pt = !pt;
      if ($urandom_range(3) == 0) ptg = $urandom;
      drive(($urandom_range(3) != 0), pe,
            32'($urandom_range(64)) * 4 - 32'd128,
            $urandom, $urandom_range(1), $urandom_range(1),
            pt, ptg, pf, ($urandom_range(40) == 0));
      check_all("rnd");
      tick();
    end

    // Asynchronous reset mid-cycle while trained.
    drive(1, 32'h200, 32'h40, 0, 0, 1, 0, 0, 32'h200, 0);
    tick();
    idle(32'h200);
    chk("pre_rst_pt", 32'(pred_taken_f), 32'h1);
    #1 rst = 1;
    #1;
    m_reset();
    chk("async_pt", 32'(pred_taken_f), 32'h0);
    chk("async_ptg", pred_target_f, 32'h0);
`ifdef BTB_STATS_EN
    chk("async_su", stat_updates, 32'h0);
    chk("async_sm", stat_mispredicts, 32'h0);
`endif
    @(negedge clk);
    rst = 0;
    idle(32'h200);
    check_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
